// File: rtl/text_engine.sv
// text_engine: walks a 4x16 character window and streams its 8x8
// glyphs as a 128x32 page-major pixel-byte frame over valid/ready.
module text_engine #(
  parameter bit         INVERT   = 1'b0,
  parameter logic [7:0] SUB_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [5:0]  char_addr,
  input  logic [7:0]  char_output,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHAR_WAIT  = 3'd1,
    CHAR_LATCH = 3'd2,
    FONT_WAIT  = 3'd3,
    FONT_LATCH = 3'd4,
    EMIT       = 3'd5
  } state_t;

  state_t      state, state_d;
  logic [5:0]  char_addr_d;
  logic [10:0] font_addr_d;
  logic [7:0]  code, code_d;
  logic [2:0]  col, col_d;
  logic [7:0]  pix_data_d;
  logic        pix_valid_d;
  logic        pix_last_d;
  logic        frame_done_d;
  logic [7:0]  san;
  logic        last_byte;

  assign san = (char_output < 8'h20 || char_output > 8'h7E)
             ? SUB_CHAR : char_output;
  assign last_byte = (char_addr == 6'd63) && (col == 3'd7);
  assign busy = (state != IDLE);

  always_comb begin
    state_d      = state;
    char_addr_d  = char_addr;
    font_addr_d  = font_addr;
    code_d       = code;
    col_d        = col;
    pix_data_d   = pix_data;
    pix_valid_d  = pix_valid;
    pix_last_d   = pix_last;
    frame_done_d = 1'b0;
    unique case (state)
      IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (frame_start && !frame_done) begin
          char_addr_d = 6'd0;
          col_d       = 3'd0;
          state_d     = CHAR_WAIT;
        end
      end
      CHAR_WAIT: state_d = CHAR_LATCH;
      CHAR_LATCH: begin
        code_d      = san;
        font_addr_d = {san, col};
        state_d     = FONT_WAIT;
      end
      FONT_WAIT: state_d = FONT_LATCH;
      FONT_LATCH: begin
        pix_data_d  = font_data ^ {8{INVERT}};
        pix_valid_d = 1'b1;
        pix_last_d  = last_byte;
        state_d     = EMIT;
      end
      EMIT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (pix_last) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else if (col == 3'd7) begin
            col_d       = 3'd0;
            char_addr_d = char_addr + 6'd1;
            state_d     = CHAR_WAIT;
          end else begin
            col_d       = col + 3'd1;
            font_addr_d = {code, col + 3'd1};
            state_d     = FONT_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      char_addr  <= 6'd0;
      font_addr  <= 11'd0;
      code       <= 8'd0;
      col        <= 3'd0;
      pix_data   <= 8'd0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      char_addr  <= char_addr_d;
      font_addr  <= font_addr_d;
      code       <= code_d;
      col        <= col_d;
      pix_data   <= pix_data_d;
      pix_valid  <= pix_valid_d;
      pix_last   <= pix_last_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_text_engine.sv
// tb_text_engine: directed checks of text_engine with flash and
// font ROM models, plus an inverted instance run in lockstep.
module tb_text_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_ready;
  logic [7:0]  char_output = 8'd0;
  logic [7:0]  font_data = 8'd0;
  logic [5:0]  char_addr, char_addr2;
  logic [10:0] font_addr, font_addr2;
  logic [7:0]  pix_data, pix_data2;
  logic        pix_valid, pix_last, busy, frame_done;
  logic        pix_valid2, pix_last2, busy2, frame_done2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  text_engine dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .char_addr(char_addr), .char_output(char_output),
    .font_addr(font_addr), .font_data(font_data),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .frame_done(frame_done)
  );

  text_engine #(.INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .char_addr(char_addr2), .char_output(char_output),
    .font_addr(font_addr2), .font_data(font_data),
    .pix_data(pix_data2), .pix_valid(pix_valid2),
    .pix_ready(pix_ready), .pix_last(pix_last2),
    .busy(busy2), .frame_done(frame_done2)
  );

  logic [7:0] mem [64];
  bit         font_zero = 1'b0;
  bit         bp_mode = 1'b0;

  function automatic logic [7:0] rom(input logic [10:0] a);
    if (font_zero) return 8'h00;
    return a[10:3] ^ {a[2:0], a[2:0], a[1:0]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    char_output <= mem[char_addr];
    font_data   <= rom(font_addr);
  end

  always @(negedge clk)
    pix_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;

  int cyc = 0;
  int t0 = 0;
  int hs_cnt, done_cnt, done_rel, first_valid_rel;
  int last_cnt, last_idx, stab_err, inv_err, busy_cnt, stall_cnt;
  logic [7:0]  bytes [512];
  logic [7:0]  bytes2 [512];
  logic [7:0]  ref_bytes [512];
  logic [10:0] fa [512];
  int          hs_rel [512];
  logic        pv_q = 1'b0, pr_q = 1'b0, pl_q = 1'b0;
  logic [7:0]  pd_q = 8'd0;

  always @(posedge clk) begin
    int rel;
    rel = cyc - t0;
    if (pix_valid && first_valid_rel < 0) first_valid_rel = rel;
    if (pv_q && !pr_q &&
        (!pix_valid || pix_data !== pd_q || pix_last !== pl_q))
      stab_err++;
    if (char_addr2 !== char_addr || font_addr2 !== font_addr ||
        pix_valid2 !== pix_valid || pix_last2 !== pix_last ||
        busy2 !== busy || frame_done2 !== frame_done ||
        (pix_valid && pix_data2 !== ~pix_data))
      inv_err++;
    if (pix_valid && !pix_ready) stall_cnt++;
    if (pix_valid && pix_ready) begin
      if (hs_cnt < 512) begin
        bytes[hs_cnt]  = pix_data;
        bytes2[hs_cnt] = pix_data2;
        fa[hs_cnt]     = font_addr;
        hs_rel[hs_cnt] = rel;
      end
      if (pix_last) begin
        last_cnt++;
        last_idx = hs_cnt;
      end
      hs_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (busy) busy_cnt++;
    pv_q = pix_valid;
    pr_q = pix_ready;
    pl_q = pix_last;
    pd_q = pix_data;
    cyc++;
  end

  task automatic reset_mon();
    hs_cnt = 0; done_cnt = 0; done_rel = -1; first_valid_rel = -1;
    last_cnt = 0; last_idx = -1; stab_err = 0; inv_err = 0;
    busy_cnt = 0; stall_cnt = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    reset_mon();
    t0 = cyc;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({char_addr, font_addr, pix_data} !== 25'd0)
      $display("FAIL reset_addr_data: got %h/%h/%h want 0/0/0",
               char_addr, font_addr, pix_data);
    else passed++;
    total++;
    if ({pix_valid, pix_last, busy, frame_done} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000",
               {pix_valid, pix_last, busy, frame_done});
    else passed++;
    rst = 1'b1;
    reset_mon();
    repeat (100) @(negedge clk);
    total++;
    if (hs_cnt !== 0 || busy_cnt !== 0 || done_cnt !== 0)
      $display("FAIL idle_quiet: got hs=%0d busy=%0d done=%0d want 0",
               hs_cnt, busy_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_full_frame();
    bit ok;
    int fa_err, d_err;
    fill_mem(8'h41);
    font_zero = 1'b0;
    start_frame();
    wait_done(2000, ok);
    total++;
    if (!ok) $display("FAIL full_timeout: got no frame_done want done");
    else passed++;
    total++;
    if (hs_cnt !== 512)
      $display("FAIL full_count: got %0d want 512", hs_cnt);
    else passed++;
    total++;
    if (first_valid_rel !== 5)
      $display("FAIL full_first_valid: got %0d want 5", first_valid_rel);
    else passed++;
    total++;
    if (hs_rel[1] !== 8 || hs_rel[8] !== 31 || hs_rel[511] !== 1664)
      $display("FAIL full_hs_timing: got %0d/%0d/%0d want 8/31/1664",
               hs_rel[1], hs_rel[8], hs_rel[511]);
    else passed++;
    total++;
    if (last_cnt !== 1 || last_idx !== 511)
      $display("FAIL full_last: got cnt=%0d idx=%0d want 1/511",
               last_cnt, last_idx);
    else passed++;
    total++;
    if (done_cnt !== 1 || done_rel !== 1665)
      $display("FAIL full_done: got cnt=%0d at %0d want 1 at 1665",
               done_cnt, done_rel);
    else passed++;
    total++;
    if (busy_cnt !== 1664 || busy !== 1'b0)
      $display("FAIL full_busy: got %0d cycles now=%b want 1664/0",
               busy_cnt, busy);
    else passed++;
    fa_err = 0;
    d_err = 0;
    for (int i = 0; i < 512; i++) begin
      if (fa[i] !== {8'h41, 3'(i)}) fa_err++;
      if (bytes[i] !== rom({8'h41, 3'(i)})) d_err++;
      ref_bytes[i] = bytes[i];
    end
    total++;
    if (fa_err !== 0)
      $display("FAIL full_font_addr: got %0d bad want 0", fa_err);
    else passed++;
    total++;
    if (d_err !== 0)
      $display("FAIL full_bytes: got %0d bad want 0", d_err);
    else passed++;
    total++;
    if (inv_err !== 0)
      $display("FAIL full_invert: got %0d bad want 0", inv_err);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int d_err;
    bp_mode = 1'b1;
    start_frame();
    wait_done(6000, ok);
    bp_mode = 1'b0;
    total++;
    if (!ok || hs_cnt !== 512)
      $display("FAIL bp_count: got ok=%0d n=%0d want 1/512", ok, hs_cnt);
    else passed++;
    total++;
    if (stall_cnt == 0 || stab_err !== 0)
      $display("FAIL bp_stable: got stalls=%0d unstable=%0d want >0/0",
               stall_cnt, stab_err);
    else passed++;
    d_err = 0;
    for (int i = 0; i < 512; i++)
      if (bytes[i] !== ref_bytes[i]) d_err++;
    total++;
    if (d_err !== 0 || last_idx !== 511)
      $display("FAIL bp_stream: got %0d bad last=%0d want 0/511",
               d_err, last_idx);
    else passed++;
  endtask

  task automatic test_sanitise();
    bit ok;
    fill_mem(8'h41);
    mem[0] = 8'h0A;
    mem[1] = 8'h7F;
    mem[2] = 8'h00;
    mem[3] = 8'h7E;
    font_zero = 1'b1;
    start_frame();
    wait_done(2000, ok);
    total++;
    if (!ok || hs_cnt !== 512)
      $display("FAIL san_count: got ok=%0d n=%0d want 1/512", ok, hs_cnt);
    else passed++;
    total++;
    if (fa[0][10:3] !== 8'h20 || fa[8][10:3] !== 8'h20 ||
        fa[16][10:3] !== 8'h20)
      $display("FAIL san_sub: got %h %h %h want 20 20 20",
               fa[0][10:3], fa[8][10:3], fa[16][10:3]);
    else passed++;
    total++;
    if (fa[24][10:3] !== 8'h7E || fa[32][10:3] !== 8'h41)
      $display("FAIL san_pass: got %h %h want 7e 41",
               fa[24][10:3], fa[32][10:3]);
    else passed++;
    total++;
    if (bytes[0] !== 8'h00 || bytes2[0] !== 8'hFF ||
        bytes2[300] !== 8'hFF)
      $display("FAIL san_invert: got %h %h %h want 00 ff ff",
               bytes[0], bytes2[0], bytes2[300]);
    else passed++;
    font_zero = 1'b0;
    fill_mem(8'h41);
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int d_err;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (pix_valid && hs_cnt == 200) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) $display("FAIL mid_reach: got no byte 200 want byte 200");
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || char_addr !== 6'd0)
      $display("FAIL mid_abort: got v=%b b=%b a=%0d want 0/0/0",
               pix_valid, busy, char_addr);
    else passed++;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt !== 0)
      $display("FAIL mid_no_done: got %0d want 0", done_cnt);
    else passed++;
    start_frame();
    total++;
    if (char_addr !== 6'd0 || busy !== 1'b1)
      $display("FAIL mid_restart: got a=%0d b=%b want 0/1",
               char_addr, busy);
    else passed++;
    wait_done(2000, ok);
    d_err = 0;
    for (int i = 0; i < 512; i++)
      if (bytes[i] !== ref_bytes[i]) d_err++;
    total++;
    if (!ok || hs_cnt !== 512 || fa[0] !== {8'h41, 3'd0} || d_err !== 0)
      $display("FAIL mid_new_frame: got ok=%0d n=%0d fa=%h bad=%0d want 1/512/208/0",
               ok, hs_cnt, fa[0], d_err);
    else passed++;
  endtask

  task automatic test_spurious();
    bit ok;
    start_frame();
    for (int i = 0; i < 100 && cyc != t0 + 50; i++) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 3000 && cyc != t0 + 1665; i++) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if (hs_cnt !== 512 || done_cnt !== 1)
      $display("FAIL spur_first: got n=%0d done=%0d want 512/1",
               hs_cnt, done_cnt);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL spur_on_done: got busy=%b want 0", busy);
    else passed++;
    reset_mon();
    t0 = cyc;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++;
    if (busy !== 1'b1)
      $display("FAIL spur_after_done: got busy=%b want 1", busy);
    else passed++;
    wait_done(2000, ok);
    total++;
    if (!ok || hs_cnt !== 512 || done_rel !== 1665)
      $display("FAIL spur_frame2: got ok=%0d n=%0d done@%0d want 1/512/1665",
               ok, hs_cnt, done_rel);
    else passed++;
  endtask

  initial begin
    fill_mem(8'h41);
    reset_mon();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_sanitise();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
